// File: rtl/combo_lock_pkg.sv
// rtl/combo_lock_pkg.sv - shared types and helpers for the parametrised combination lock
package combo_lock_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED,
    ST_OPEN,
    ST_PROG,
    ST_LOCKOUT
  } lock_state_t;

  // Widths for the default configuration; instances recompute from their own parameters.
  localparam int IDX_W  = $clog2(4 + 1);
  localparam int FAIL_W = $clog2(3 + 1);

  localparam int MAX_CODE_BITS = 256;

  // Digit 0 is the most significant digit of the packed code.
  function automatic logic [31:0] get_digit(input logic [MAX_CODE_BITS-1:0] packed_code,
                                            input int idx, input int seq_len, input int code_w);
    logic [MAX_CODE_BITS-1:0] shifted;
    shifted = packed_code >> ((seq_len - 1 - idx) * code_w);
    return shifted[31:0] & ((32'd1 << code_w) - 32'd1);
  endfunction

endpackage

// File: rtl/combo_lockout_timer.sv
// rtl/combo_lockout_timer.sv - down-counter holding the lock in lockout; busy while nonzero
module combo_lockout_timer #(
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic busy
);

  localparam int CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (start) begin
      count <= CW'(LOCKOUT_CYCLES - 1);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/combo_lock_param.sv
// rtl/combo_lock_param.sv - multi-digit combination lock with fail counting, lockout and runtime reprogramming
module combo_lock_param
  import combo_lock_pkg::*;
#(
  parameter int CODE_W = 4,
  parameter int SEQ_LEN = 4,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 1024,
  parameter logic [SEQ_LEN*CODE_W-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             masterRST,
  input  logic [CODE_W-1:0]                code,
  input  logic                             code_valid,
  input  logic                             prog_req,
  input  logic                             relock,
  output logic                             unlocked,
  output logic                             lockout,
  output logic                             prog_mode,
  output logic                             err,
  output logic [$clog2(SEQ_LEN+1)-1:0]     digit_idx,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

  localparam int IW = $clog2(SEQ_LEN + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int CB = SEQ_LEN * CODE_W;
  localparam logic [IW-1:0] LAST_IDX = IW'(SEQ_LEN - 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);

  lock_state_t state, next_state;
  logic [CB-1:0] stored_code, shadow, shadow_nx;
  logic          mismatch_flag, err_q, timer_busy, timer_start;
  logic          last_digit, entry_bad;
  logic [CODE_W-1:0] expected_digit;
  logic [FW-1:0] fail_inc;

  assign expected_digit = CODE_W'(get_digit(MAX_CODE_BITS'(stored_code), int'(digit_idx), SEQ_LEN, CODE_W));
  assign last_digit     = (digit_idx == LAST_IDX);
  assign entry_bad      = mismatch_flag | (code != expected_digit);
  assign fail_inc       = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;

  always_comb begin
    shadow_nx = shadow;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (digit_idx == IW'(i)) shadow_nx[(SEQ_LEN-1-i)*CODE_W +: CODE_W] = code;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_LOCKED;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (masterRST) begin
      next_state = ST_LOCKED;
    end else begin
      case (state)
        ST_LOCKED:
          if (!relock && code_valid && last_digit) begin
            if (!entry_bad)               next_state = ST_OPEN;
            else if (fail_inc == FAIL_MAX) next_state = ST_LOCKOUT;
          end
        ST_OPEN:
          if (relock)        next_state = ST_LOCKED;
          else if (prog_req) next_state = ST_PROG;
        ST_PROG:
          if (relock || (code_valid && last_digit)) next_state = ST_LOCKED;
        ST_LOCKOUT:
          if (!timer_busy) next_state = ST_LOCKED;
        default: next_state = ST_LOCKED;
      endcase
    end
  end

  always_comb begin
    unlocked  = (state == ST_OPEN);
    lockout   = (state == ST_LOCKOUT);
    prog_mode = (state == ST_PROG);
    err       = err_q;
  end

  // Entry progress, fail history and the programmable code.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stored_code   <= DEFAULT_CODE;
      shadow        <= '0;
      digit_idx     <= '0;
      fail_cnt      <= '0;
      mismatch_flag <= 1'b0;
      err_q         <= 1'b0;
    end else if (masterRST) begin
      stored_code   <= DEFAULT_CODE;
      shadow        <= '0;
      digit_idx     <= '0;
      fail_cnt      <= '0;
      mismatch_flag <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_LOCKED:
          if (relock) begin
            digit_idx     <= '0;
            mismatch_flag <= 1'b0;
          end else if (code_valid) begin
            if (last_digit) begin
              digit_idx     <= '0;
              mismatch_flag <= 1'b0;
              if (entry_bad) begin
                err_q    <= 1'b1;
                fail_cnt <= fail_inc;
              end else begin
                fail_cnt <= '0;
              end
            end else begin
              digit_idx     <= digit_idx + 1'b1;
              mismatch_flag <= entry_bad;
            end
          end
        ST_OPEN:
          if (!relock && prog_req) digit_idx <= '0;
        ST_PROG:
          if (relock) begin
            digit_idx <= '0;
            shadow    <= '0;
          end else if (code_valid) begin
            shadow <= shadow_nx;
            if (last_digit) begin
              stored_code <= shadow_nx;
              digit_idx   <= '0;
            end else begin
              digit_idx <= digit_idx + 1'b1;
            end
          end
        ST_LOCKOUT:
          if (!timer_busy) fail_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign timer_start = (state == ST_LOCKED) && (next_state == ST_LOCKOUT);

  combo_lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_timer (
    .clk  (CLK),
    .rst  (RST),
    .start(timer_start),
    .clear(masterRST),
    .busy (timer_busy)
  );

endmodule
